// File: rtl/pacman_soc_onchip_ram_pipelined_pkg.sv
// Shared types and elaboration helpers for the pipelined on-chip RAM slave.
//   mem_state_e      : controller state (clear engine running / serving bus)
//   DEF_*            : default geometry used by the top-level parameters
//   bytes_of/depth_of: derive lane count and word count from widths
//   read_latency_ok  : legal READ_LATENCY values are 1 and 2
package pacman_soc_mem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } mem_state_e;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 15;
  localparam int unsigned DEF_BYTES      = DEF_DATA_WIDTH / 8;
  localparam int unsigned DEF_DEPTH      = 1 << DEF_ADDR_WIDTH;

  function automatic int unsigned bytes_of(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 1 << addr_width;
  endfunction

  function automatic bit read_latency_ok(input int unsigned read_latency);
    return (read_latency == 1) || (read_latency == 2);
  endfunction

endpackage

// File: rtl/pacman_soc_onchip_ram_pipelined_if.sv
// Avalon-MM pipelined slave bus bundle for the on-chip RAM.
//   master modport: drives address/byteenable/chipselect/read/write/writedata/clken,
//                   receives readdata/readdatavalid/waitrequest
//   slave modport : the mirror image
interface pacman_soc_onchip_ram_pipelined_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 15
);
  localparam int unsigned BYTES = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] address;
  logic [BYTES-1:0]      byteenable;
  logic                  chipselect;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] writedata;
  logic                  clken;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdatavalid;
  logic                  waitrequest;

  modport master (
    output address, byteenable, chipselect, read, write, writedata, clken,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata, clken,
    output readdata, readdatavalid, waitrequest
  );

endinterface

// File: rtl/pacman_soc_onchip_ram_pipelined_ram_core.sv
// Single-port byte-enabled RAM with registered address (read data follows the
// address register combinationally, so a write is visible to a read issued on
// the following cycle).
//   clk     : clock
//   en      : clock enable, freezes the array and address register when low
//   we/be   : write strobe and byte-lane enables
//   addr    : word address
//   wdata   : write data
//   rdata_c : word at the registered address
module pacman_soc_ram_core
  import pacman_soc_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                            clk,
  input  logic                            en,
  input  logic                            we,
  input  logic [bytes_of(DATA_WIDTH)-1:0] be,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [DATA_WIDTH-1:0]           wdata,
  output logic [DATA_WIDTH-1:0]           rdata_c
);
  localparam int unsigned BYTES = bytes_of(DATA_WIDTH);
  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q;

  // Byte-lane write and address capture, both held while en is low.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < BYTES; b++) begin
          if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
      addr_q <= addr;
    end
  end

  assign rdata_c = mem[addr_q];

endmodule

// File: rtl/pacman_soc_onchip_ram_pipelined.sv
// Avalon-MM pipelined on-chip RAM slave with post-reset zero-fill engine.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : address/byteenable/chipselect/read/write/writedata/clken in,
//                  readdata/readdatavalid/waitrequest out
//   init_done    : high once the array is ready for traffic
// With CLEAR_ON_RESET=0 the array image named by INIT_FILE is expected to be
// preloaded by the implementation flow's memory-initialisation step.
module pacman_soc_onchip_ram_pipelined
  import pacman_soc_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter string       INIT_FILE      = "pacman_soc_onchip_memory.hex"
) (
  input  logic                              clk,
  input  logic                              reset_n,
  pacman_soc_onchip_ram_pipelined_if.slave  bus,
  output logic                              init_done
);
  localparam int unsigned BYTES = bytes_of(DATA_WIDTH);
  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST_ADDR = CW'(DEPTH - 1);

  // Elaboration guards on the parameter set.
  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (!CLEAR_ON_RESET && (INIT_FILE == "")) begin : g_no_image
    $error("INIT_FILE required when CLEAR_ON_RESET=0");
  end

  mem_state_e      state_q, state_d;
  logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            init_done_d;
  logic            waitrequest_c;
  logic            wr_acc_c, rd_acc_c;
  logic            acc_vld_q;
  logic            readdatavalid_q;
  logic [DATA_WIDTH-1:0] readdata_q;

  logic                  ram_we_c;
  logic [BYTES-1:0]      ram_be_c;
  logic [ADDR_WIDTH-1:0] ram_addr_c;
  logic [DATA_WIDTH-1:0] ram_wdata_c;
  logic [DATA_WIDTH-1:0] ram_rdata_c;

  // Handshake: write wins over a simultaneous read.
  assign waitrequest_c = (state_q != ST_READY) | ~bus.clken;
  assign wr_acc_c = bus.chipselect & bus.write & ~waitrequest_c;
  assign rd_acc_c = bus.chipselect & bus.read & ~bus.write & ~waitrequest_c;

  assign bus.waitrequest   = waitrequest_c;
  assign bus.readdata      = readdata_q;
  assign bus.readdatavalid = readdatavalid_q;

  // Next-state: clear engine walks every address once, then serves the bus.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done;
    if (bus.clken) begin
      case (state_q)
        ST_CLEAR: begin
          if (!CLEAR_ON_RESET) begin
            state_d     = ST_READY;
            init_done_d = 1'b1;
          end else begin
            clr_cnt_d = clr_cnt_q + CW'(1);
            if (clr_cnt_q == LAST_ADDR) begin
              state_d     = ST_READY;
              init_done_d = 1'b1;
            end
          end
        end
        ST_READY: state_d = ST_READY;
        default:  state_d = ST_CLEAR;
      endcase
    end
  end

  // State, counter and accept-stage valid registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      init_done <= 1'b0;
      acc_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      init_done <= init_done_d;
      if (bus.clken) acc_vld_q <= rd_acc_c;
    end
  end

  // RAM port owner: clear engine during CLEAR, bus master afterwards.
  always_comb begin
    ram_we_c    = wr_acc_c;
    ram_be_c    = bus.byteenable;
    ram_addr_c  = bus.address;
    ram_wdata_c = bus.writedata;
    if (state_q == ST_CLEAR) begin
      ram_we_c    = CLEAR_ON_RESET;
      ram_be_c    = '1;
      ram_addr_c  = clr_cnt_q[ADDR_WIDTH-1:0];
      ram_wdata_c = '0;
    end
  end

  pacman_soc_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clk     (clk),
    .en      (bus.clken),
    .we      (ram_we_c),
    .be      (ram_be_c),
    .addr    (ram_addr_c),
    .wdata   (ram_wdata_c),
    .rdata_c (ram_rdata_c)
  );

  // Response pipeline; readdata only loads on a valid beat so it holds otherwise.
  if (READ_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        readdatavalid_q <= 1'b0;
        readdata_q      <= '0;
      end else if (bus.clken) begin
        readdatavalid_q <= acc_vld_q;
        if (acc_vld_q) readdata_q <= ram_rdata_c;
      end
    end
  end else begin : g_lat2
    logic                  stage_vld_q;
    logic [DATA_WIDTH-1:0] stage_data_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        stage_vld_q     <= 1'b0;
        stage_data_q    <= '0;
        readdatavalid_q <= 1'b0;
        readdata_q      <= '0;
      end else if (bus.clken) begin
        stage_vld_q <= acc_vld_q;
        if (acc_vld_q) stage_data_q <= ram_rdata_c;
        readdatavalid_q <= stage_vld_q;
        if (stage_vld_q) readdata_q <= stage_data_q;
      end
    end
  end

endmodule

// File: tb/tb_pacman_soc_onchip_ram_pipelined.sv
// Self-checking bench: two instances (read latency 1 and 2) share one stimulus
// stream and are compared every cycle against a transaction-level model.
module tb_pacman_soc_onchip_ram_pipelined;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned BY = DW / 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset_n;
  logic done1, done2;
  always #5 clk = ~clk;

  pacman_soc_onchip_ram_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
  pacman_soc_onchip_ram_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

  pacman_soc_onchip_ram_pipelined #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1),
    .INIT_FILE("pacman_soc_onchip_memory.hex")
  ) u_dut_l1 (.clk(clk), .reset_n(reset_n), .bus(bus1), .init_done(done1));

  pacman_soc_onchip_ram_pipelined #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1),
    .INIT_FILE("pacman_soc_onchip_memory.hex")
  ) u_dut_l2 (.clk(clk), .reset_n(reset_n), .bus(bus2), .init_done(done2));

  // Reference model: memory image, readiness, and per-instance response queues.
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } resp_t;

  logic [DW-1:0] mem_m [DEPTH];
  bit            ready_m;
  int            clr_m;
  int            ecyc;
  resp_t         q0[$];
  resp_t         q1[$];
  logic [DW-1:0] exp_rd [2];
  bit            exp_rdv [2];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit cs, input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [BY-1:0] be, input logic [DW-1:0] wd, input bit ce);
    bus1.chipselect = cs; bus2.chipselect = cs;
    bus1.read = rd;       bus2.read = rd;
    bus1.write = wr;      bus2.write = wr;
    bus1.address = a;     bus2.address = a;
    bus1.byteenable = be; bus2.byteenable = be;
    bus1.writedata = wd;  bus2.writedata = wd;
    bus1.clken = ce;      bus2.clken = ce;
  endtask

  function automatic void retire(input int d);
    resp_t r;
    if (d == 0) begin
      if (q0.size() != 0 && q0[0].due == ecyc) begin
        r = q0.pop_front(); exp_rd[0] = r.data; exp_rdv[0] = 1'b1;
      end else exp_rdv[0] = 1'b0;
    end else begin
      if (q1.size() != 0 && q1[0].due == ecyc) begin
        r = q1.pop_front(); exp_rd[1] = r.data; exp_rdv[1] = 1'b1;
      end else exp_rdv[1] = 1'b0;
    end
  endfunction

  task automatic check_outputs(input string ph);
    chk({ph, "_rdv_l1"},  64'(bus1.readdatavalid), 64'(exp_rdv[0]));
    chk({ph, "_rdv_l2"},  64'(bus2.readdatavalid), 64'(exp_rdv[1]));
    chk({ph, "_rd_l1"},   64'(bus1.readdata), 64'(exp_rd[0]));
    chk({ph, "_rd_l2"},   64'(bus2.readdata), 64'(exp_rd[1]));
    chk({ph, "_done_l1"}, 64'(done1), 64'(ready_m));
    chk({ph, "_done_l2"}, 64'(done2), 64'(ready_m));
  endtask

  // One bus cycle, entered and left at the falling edge.
  task automatic cycle(input bit cs, input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [BY-1:0] be, input logic [DW-1:0] wd, input bit ce);
    bit acc_rd, acc_wr;
    drive(cs, rd, wr, a, be, wd, ce);
    #1;
    chk("waitreq_l1", 64'(bus1.waitrequest), 64'(!ready_m || !ce));
    chk("waitreq_l2", 64'(bus2.waitrequest), 64'(!ready_m || !ce));
    acc_wr = reset_n && ce && ready_m && cs && wr;
    acc_rd = reset_n && ce && ready_m && cs && rd && !wr;
    @(posedge clk);
    if (reset_n && ce) begin
      ecyc++;
      retire(0);
      retire(1);
      if (acc_rd) begin
        q0.push_back('{data: mem_m[a], due: ecyc + 1});
        q1.push_back('{data: mem_m[a], due: ecyc + 2});
      end
      if (acc_wr) begin
        for (int b = 0; b < BY; b++) if (be[b]) mem_m[a][b*8 +: 8] = wd[b*8 +: 8];
      end
      if (!ready_m) begin
        clr_m++;
        if (clr_m == DEPTH) begin
          ready_m = 1'b1;
          for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        end
      end
    end
    #1;
    check_outputs("cyc");
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
  endtask

  // Asynchronous reset assertion from a falling edge; checks outputs before the next clock.
  task automatic assert_reset(input string ph);
    reset_n = 1'b0;
    ready_m = 1'b0; clr_m = 0;
    q0.delete(); q1.delete();
    exp_rdv[0] = 1'b0; exp_rdv[1] = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    #1;
    check_outputs(ph);
    chk({ph, "_waitreq_l1"}, 64'(bus1.waitrequest), 64'd1);
    chk({ph, "_waitreq_l2"}, 64'(bus2.waitrequest), 64'd1);
    @(negedge clk);
    idle(2);
    reset_n = 1'b1;
  endtask

  task automatic wait_clear(input string ph);
    int wr_cycles;
    wr_cycles = 0;
    for (int i = 0; i < 40 && !done1; i++) begin
      if (bus1.waitrequest) wr_cycles++;
      idle(1);
    end
    chk({ph, "_clear_cycles"}, 64'(wr_cycles), 64'd16);
    chk({ph, "_init_done"}, 64'(done1 & done2), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ecyc = 0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    @(negedge clk);
    assert_reset("reset");

    // Interrupt the first clear after seven writes; it must restart from scratch.
    idle(7);
    chk("mid_clear_count", 64'(clr_m), 64'd7);
    assert_reset("reset_mid_clear");
    wait_clear("clear");

    // Every word reads back as zero after the clear.
    for (int a = 0; a < DEPTH; a++) cycle(1'b1, 1'b1, 1'b0, AW'(a), '0, '0, 1'b1);
    idle(3);

    // Byte-lane merge.
    cycle(1'b1, 1'b0, 1'b1, 4'd3, 4'b0101, 32'hDEADBEEF, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 4'd3, '0, '0, 1'b1);
    idle(3);
    chk("be_merge_l1", 64'(bus1.readdata), 64'h00AD00EF);
    chk("be_merge_l2", 64'(bus2.readdata), 64'h00AD00EF);

    // Back-to-back reads of distinct words, in order.
    cycle(1'b1, 1'b0, 1'b1, 4'd1, 4'hF, 32'h11, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 4'd2, 4'hF, 32'h22, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 4'd3, 4'hF, 32'h33, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 4'd1, '0, '0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 4'd2, '0, '0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 4'd3, '0, '0, 1'b1);
    idle(3);
    chk("burst_last_l2", 64'(bus2.readdata), 64'h33);

    // Read right after write, and read+write together (write only, no response).
    cycle(1'b1, 1'b0, 1'b1, 4'd5, 4'hF, 32'hCAFE0000, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 4'd5, '0, '0, 1'b1);
    idle(3);
    chk("raw_l1", 64'(bus1.readdata), 64'hCAFE0000);
    cycle(1'b1, 1'b1, 1'b1, 4'd6, 4'hF, 32'h66666666, 1'b1);
    idle(3);
    chk("rw_no_resp_l1", 64'(bus1.readdata), 64'hCAFE0000);
    cycle(1'b1, 1'b1, 1'b0, 4'd6, '0, '0, 1'b1);
    idle(3);
    chk("rw_write_done_l2", 64'(bus2.readdata), 64'h66666666);

    // In-flight read stalled by clken low for three cycles.
    cycle(1'b1, 1'b1, 1'b0, 4'd3, '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    chk("stall_no_rdv_l1", 64'(bus1.readdatavalid), 64'd0);
    idle(1);
    chk("stall_rdv_l1", 64'(bus1.readdatavalid), 64'd1);
    idle(3);

    // Randomised traffic with clock-enable gaps.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), AW'($urandom),
            BY'($urandom), DW'($urandom), $urandom_range(0, 7) != 0);
    end
    idle(4);

    // Reset with a read in flight drops the response and restarts the clear.
    cycle(1'b1, 1'b1, 1'b0, 4'd5, '0, '0, 1'b1);
    assert_reset("reset_mid_read");
    wait_clear("reclear");
    for (int a = 3; a < 7; a++) cycle(1'b1, 1'b1, 1'b0, AW'(a), '0, '0, 1'b1);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
